// File: rtl/multi_alarm_clock.sv
// 24-hour BCD real-time clock with N programmable hh:mm alarms, snooze and ring timeout.
// A prescaler derives the 1 s tick; a three-state ring controller drives alarm/snoozing.
module multi_alarm_clock #(
  parameter int CLK_HZ     = 10,
  parameter int N_ALARMS   = 4,
  parameter int AIDX_W     = 2,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ld_time,
  input  logic                ld_alarm,
  input  logic [AIDX_W-1:0]   alarm_sel,
  input  logic [1:0]          set_h1,
  input  logic [3:0]          set_h0,
  input  logic [2:0]          set_m1,
  input  logic [3:0]          set_m0,
  input  logic [N_ALARMS-1:0] alarm_en,
  input  logic                stop_alarm,
  input  logic                snooze,
  output logic [1:0]          h1,
  output logic [3:0]          h0,
  output logic [2:0]          m1,
  output logic [3:0]          m0,
  output logic [2:0]          s1,
  output logic [3:0]          s0,
  output logic                tick_1s,
  output logic                alarm,
  output logic [N_ALARMS-1:0] alarm_src,
  output logic                snoozing,
  output logic                ld_err
);

  localparam int PS_W   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int RING_W = $clog2(RING_SEC + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_SEC + 1);
  localparam logic [31:0] N_ALARMS_U = N_ALARMS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZE  = 2'd2
  } state_t;

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_q, tick_d;
  logic            wrap;
  logic [1:0]      h1_q, h1_d;
  logic [3:0]      h0_q, h0_d;
  logic [2:0]      m1_q, m1_d;
  logic [3:0]      m0_q, m0_d;
  logic [2:0]      s1_q, s1_d;
  logic [3:0]      s0_q, s0_d;
  logic [12:0]     slot_q [N_ALARMS];
  logic [12:0]     slot_d [N_ALARMS];
  logic            ld_err_q, ld_err_d;

  state_t              state_q, state_d;
  logic [N_ALARMS-1:0] src_q, src_d;
  logic [RING_W-1:0]   ring_q, ring_d;
  logic [SNZ_W-1:0]    snz_q, snz_d;
  logic                alarm_q, alarm_d;
  logic                snoozing_q, snoozing_d;

  logic                set_valid;
  logic                sel_ok;
  logic                time_load;
  logic [12:0]         set_word;
  logic [12:0]         cur_hm;
  logic [N_ALARMS-1:0] match;

  assign set_valid = (set_h1 <= 2'd2) && (set_h0 <= 4'd9) &&
                     ((set_h1 != 2'd2) || (set_h0 <= 4'd3)) &&
                     (set_m1 <= 3'd5) && (set_m0 <= 4'd9);
  assign sel_ok    = (32'(alarm_sel) < N_ALARMS_U);
  assign time_load = ld_time && set_valid;
  assign set_word  = {set_h1, set_h0, set_m1, set_m0};
  assign cur_hm    = {h1_q, h0_q, m1_q, m0_q};

  // Prescaler; a valid time load restarts the second and suppresses this cycle's tick.
  always_comb begin
    wrap   = (ps_q == PS_W'(CLK_HZ - 1));
    ps_d   = wrap ? '0 : ps_q + PS_W'(1);
    tick_d = wrap;
    if (time_load) begin
      ps_d   = '0;
      tick_d = 1'b0;
    end
  end

  always_comb begin
    h1_d = h1_q;
    h0_d = h0_q;
    m1_d = m1_q;
    m0_d = m0_q;
    s1_d = s1_q;
    s0_d = s0_q;
    if (time_load) begin
      h1_d = set_h1;
      h0_d = set_h0;
      m1_d = set_m1;
      m0_d = set_m0;
      s1_d = '0;
      s0_d = '0;
    end else if (wrap) begin
      if (s0_q != 4'd9) begin
        s0_d = s0_q + 4'd1;
      end else begin
        s0_d = '0;
        if (s1_q != 3'd5) begin
          s1_d = s1_q + 3'd1;
        end else begin
          s1_d = '0;
          if (m0_q != 4'd9) begin
            m0_d = m0_q + 4'd1;
          end else begin
            m0_d = '0;
            if (m1_q != 3'd5) begin
              m1_d = m1_q + 3'd1;
            end else begin
              m1_d = '0;
              if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
                h1_d = '0;
                h0_d = '0;
              end else if (h0_q == 4'd9) begin
                h0_d = '0;
                h1_d = h1_q + 2'd1;
              end else begin
                h0_d = h0_q + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      slot_d[i] = slot_q[i];
      if (ld_alarm && set_valid && (alarm_sel == AIDX_W'(i))) begin
        slot_d[i] = set_word;
      end
    end
    ld_err_d = (ld_time && !set_valid) || (ld_alarm && !(set_valid && sel_ok));
  end

  // tick_q marks the cycle in which the freshly advanced time is visible.
  always_comb begin
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      match[i] = tick_q && alarm_en[i] && (s1_q == 3'd0) && (s0_q == 4'd0) &&
                 (cur_hm == slot_q[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps_q     <= '0;
      tick_q   <= 1'b0;
      h1_q     <= '0;
      h0_q     <= '0;
      m1_q     <= '0;
      m0_q     <= '0;
      s1_q     <= '0;
      s0_q     <= '0;
      ld_err_q <= 1'b0;
      for (int unsigned i = 0; i < N_ALARMS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      ps_q     <= ps_d;
      tick_q   <= tick_d;
      h1_q     <= h1_d;
      h0_q     <= h0_d;
      m1_q     <= m1_d;
      m0_q     <= m0_d;
      s1_q     <= s1_d;
      s0_q     <= s0_d;
      ld_err_q <= ld_err_d;
      for (int unsigned i = 0; i < N_ALARMS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    case (state_q)
      S_IDLE: begin
        if (!stop_alarm && (|match)) begin
          state_d = S_RINGING;
          src_d   = match;
          ring_d  = RING_W'(RING_SEC);
        end
      end
      S_RINGING: begin
        if (stop_alarm) begin
          state_d = S_IDLE;
          src_d   = '0;
        end else if (snooze) begin
          state_d = S_SNOOZE;
          src_d   = src_q | match;
          snz_d   = SNZ_W'(SNOOZE_SEC);
        end else if (|match) begin
          src_d  = src_q | match;
          ring_d = RING_W'(RING_SEC);
        end else if (tick_q) begin
          if (ring_q <= RING_W'(1)) begin
            state_d = S_IDLE;
            src_d   = '0;
            ring_d  = '0;
          end else begin
            ring_d = ring_q - RING_W'(1);
          end
        end
      end
      S_SNOOZE: begin
        if (stop_alarm) begin
          state_d = S_IDLE;
          src_d   = '0;
        end else if (|match) begin
          state_d = S_RINGING;
          src_d   = src_q | match;
          ring_d  = RING_W'(RING_SEC);
        end else if (tick_q) begin
          if (snz_q <= SNZ_W'(1)) begin
            state_d = S_RINGING;
            snz_d   = '0;
            ring_d  = RING_W'(RING_SEC);
          end else begin
            snz_d = snz_q - SNZ_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        src_d   = '0;
      end
    endcase
  end

  always_comb begin
    alarm_d    = (state_d == S_RINGING);
    snoozing_d = (state_d == S_SNOOZE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q      <= '0;
      ring_q     <= '0;
      snz_q      <= '0;
      alarm_q    <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      src_q      <= src_d;
      ring_q     <= ring_d;
      snz_q      <= snz_d;
      alarm_q    <= alarm_d;
      snoozing_q <= snoozing_d;
    end
  end

  assign h1        = h1_q;
  assign h0        = h0_q;
  assign m1        = m1_q;
  assign m0        = m0_q;
  assign s1        = s1_q;
  assign s0        = s0_q;
  assign tick_1s   = tick_q;
  assign ld_err    = ld_err_q;
  assign alarm     = alarm_q;
  assign snoozing  = snoozing_q;
  assign alarm_src = src_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Self-checking bench for multi_alarm_clock: directed scenarios plus random stimulus,
// compared every cycle against a seconds-of-day behavioural model.
module tb_multi_alarm_clock;

  localparam int CLK_HZ     = 10;
  localparam int N_ALARMS   = 3;
  localparam int AIDX_W     = 2;
  localparam int SNOOZE_SEC = 300;
  localparam int RING_SEC   = 60;

  logic                clock;
  logic                reset;
  logic                ld_time, ld_alarm;
  logic [AIDX_W-1:0]   alarm_sel;
  logic [1:0]          set_h1;
  logic [3:0]          set_h0;
  logic [2:0]          set_m1;
  logic [3:0]          set_m0;
  logic [N_ALARMS-1:0] alarm_en;
  logic                stop_alarm, snooze;
  logic [1:0]          h1;
  logic [3:0]          h0;
  logic [2:0]          m1;
  logic [3:0]          m0;
  logic [2:0]          s1;
  logic [3:0]          s0;
  logic                tick_1s, alarm, snoozing, ld_err;
  logic [N_ALARMS-1:0] alarm_src;

  multi_alarm_clock #(
    .CLK_HZ(CLK_HZ), .N_ALARMS(N_ALARMS), .AIDX_W(AIDX_W),
    .SNOOZE_SEC(SNOOZE_SEC), .RING_SEC(RING_SEC)
  ) dut (
    .clock(clock), .reset(reset), .ld_time(ld_time), .ld_alarm(ld_alarm),
    .alarm_sel(alarm_sel), .set_h1(set_h1), .set_h0(set_h0), .set_m1(set_m1),
    .set_m0(set_m0), .alarm_en(alarm_en), .stop_alarm(stop_alarm), .snooze(snooze),
    .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0), .tick_1s(tick_1s),
    .alarm(alarm), .alarm_src(alarm_src), .snoozing(snoozing), .ld_err(ld_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 60)
        $display("FAIL %s: got %0d expected %0d at time %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: time as seconds of day, alarms as minutes of day.
  int                  m_secs, m_pcnt;
  bit                  m_tick, m_err;
  int                  m_slot [N_ALARMS];
  bit                  m_ring, m_snz;
  bit [N_ALARMS-1:0]   m_src, t_hit;
  int                  m_ring_left, m_snz_left;
  int                  t_hh, t_mm;
  bit                  t_ok, t_sel_ok;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_secs = 0; m_pcnt = 0; m_tick = 0; m_err = 0;
      m_ring = 0; m_snz = 0; m_src = '0; m_ring_left = 0; m_snz_left = 0;
      for (int i = 0; i < N_ALARMS; i++) m_slot[i] = 0;
    end else begin
      t_hh = int'(set_h1) * 10 + int'(set_h0);
      t_mm = int'(set_m1) * 10 + int'(set_m0);
      t_ok = (set_h0 <= 9) && (set_m0 <= 9) && (set_m1 <= 5) && (t_hh <= 23);
      t_sel_ok = int'(alarm_sel) < N_ALARMS;
      t_hit = '0;
      for (int i = 0; i < N_ALARMS; i++)
        if (m_tick && alarm_en[i] && (m_secs % 60 == 0) && (m_secs / 60 == m_slot[i]))
          t_hit[i] = 1'b1;
      if (m_ring) begin
        if (stop_alarm) begin m_ring = 0; m_src = '0; end
        else if (snooze) begin m_ring = 0; m_snz = 1; m_snz_left = SNOOZE_SEC; m_src |= t_hit; end
        else if (t_hit != 0) begin m_src |= t_hit; m_ring_left = RING_SEC; end
        else if (m_tick) begin
          m_ring_left--;
          if (m_ring_left == 0) begin m_ring = 0; m_src = '0; end
        end
      end else if (m_snz) begin
        if (stop_alarm) begin m_snz = 0; m_src = '0; end
        else if (t_hit != 0) begin m_snz = 0; m_ring = 1; m_src |= t_hit; m_ring_left = RING_SEC; end
        else if (m_tick) begin
          m_snz_left--;
          if (m_snz_left == 0) begin m_snz = 0; m_ring = 1; m_ring_left = RING_SEC; end
        end
      end else if (!stop_alarm && t_hit != 0) begin
        m_ring = 1; m_src = t_hit; m_ring_left = RING_SEC;
      end
      m_err = (ld_time && !t_ok) || (ld_alarm && !(t_ok && t_sel_ok));
      if (ld_alarm && t_ok && t_sel_ok) m_slot[int'(alarm_sel)] = t_hh * 60 + t_mm;
      if (ld_time && t_ok) begin
        m_secs = (t_hh * 60 + t_mm) * 60; m_pcnt = 0; m_tick = 0;
      end else if (m_pcnt == CLK_HZ - 1) begin
        m_pcnt = 0; m_tick = 1; m_secs = (m_secs + 1) % 86400;
      end else begin
        m_pcnt++; m_tick = 0;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      check("h1", int'(h1), (m_secs / 3600) / 10);
      check("h0", int'(h0), (m_secs / 3600) % 10);
      check("m1", int'(m1), ((m_secs / 60) % 60) / 10);
      check("m0", int'(m0), ((m_secs / 60) % 60) % 10);
      check("s1", int'(s1), (m_secs % 60) / 10);
      check("s0", int'(s0), (m_secs % 60) % 10);
      check("tick_1s", int'(tick_1s), int'(m_tick));
      check("ld_err", int'(ld_err), int'(m_err));
      check("alarm", int'(alarm), int'(m_ring));
      check("snoozing", int'(snoozing), int'(m_snz));
      check("alarm_src", int'(alarm_src), int'(m_src));
    end
  end

  task automatic set_hm(input int hh, input int mm);
    set_h1 = 2'(hh / 10); set_h0 = 4'(hh % 10);
    set_m1 = 3'(mm / 10); set_m0 = 4'(mm % 10);
  endtask

  task automatic load_time(input int hh, input int mm);
    set_hm(hh, mm); ld_time = 1'b1;
    @(negedge clock); ld_time = 1'b0;
  endtask

  task automatic load_alarm(input int sel, input int hh, input int mm);
    set_hm(hh, mm); alarm_sel = AIDX_W'(sel); ld_alarm = 1'b1;
    @(negedge clock); ld_alarm = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    int budget;
    seen = 0;
    budget = n * CLK_HZ + 2 * CLK_HZ;
    while (seen < n && budget > 0) begin
      @(negedge clock); budget--;
      if (tick_1s) seen++;
    end
    check("tick_wait", seen, n);
  endtask

  task automatic check_time(input string name, input int hh, input int mm, input int ss);
    check(name, ((int'(h1) * 10 + int'(h0)) * 60 + int'(m1) * 10 + int'(m0)) * 60
                + int'(s1) * 10 + int'(s0), (hh * 60 + mm) * 60 + ss);
  endtask

  task automatic check_idle_outs(input string name);
    check(name, {28'd0, alarm, snoozing, tick_1s, ld_err}, 0);
    check({name, "_src"}, int'(alarm_src), 0);
    check_time({name, "_time"}, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int tcount;
    reset = 1'b1;
    ld_time = 0; ld_alarm = 0; alarm_sel = '0; stop_alarm = 0; snooze = 0;
    alarm_en = '0; set_hm(0, 0);
    repeat (3) @(negedge clock);
    check_idle_outs("reset");
    reset = 1'b0;
    chk_en = 1'b1;

    // First tick arrives on the CLK_HZ-th cycle after reset.
    tcount = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (tick_1s) tcount++;
      if (i == 10) check("tick_on_10th", int'(tick_1s), 1);
    end
    check("tick_count_10", tcount, 1);
    check_time("time_after_10", 0, 0, 1);
    check("model_secs_10", m_secs, 1);

    // Load 23:59, reject bad loads, then roll over midnight.
    load_time(23, 59);
    check_time("load_2359", 23, 59, 0);
    load_time(24, 0);
    check("err_24_00", int'(ld_err), 1);
    check_time("keep_after_24", 23, 59, 0);
    load_time(12, 60);
    check("err_12_60", int'(ld_err), 1);
    check_time("keep_after_1260", 23, 59, 0);
    load_alarm(3, 12, 0);
    check("err_sel_oob", int'(ld_err), 1);
    @(negedge clock);
    check("err_clears", int'(ld_err), 0);
    wait_ticks(60);
    check_time("wrap_midnight", 0, 0, 0);
    check("model_wrap", m_secs, 0);

    // Two slots on 06:30, ring timeout.
    load_alarm(0, 6, 30);
    load_alarm(2, 6, 30);
    load_alarm(1, 7, 0);
    alarm_en = 3'b101;
    load_time(6, 29);
    wait_ticks(59);
    check_time("at_062959", 6, 29, 59);
    wait_ticks(1);
    check("alarm_not_yet", int'(alarm), 0);
    @(negedge clock);
    check("alarm_rise", int'(alarm), 1);
    check("src_101", int'(alarm_src), 5);
    wait_ticks(RING_SEC);
    check("ring_last", int'(alarm), 1);
    @(negedge clock);
    check("ring_timeout", int'(alarm), 0);
    check("ring_src_clr", int'(alarm_src), 0);

    // Snooze, re-ring, then stop+snooze together.
    load_time(6, 29);
    wait_ticks(60);
    @(negedge clock);
    check("alarm_rise2", int'(alarm), 1);
    snooze = 1'b1; @(negedge clock); snooze = 1'b0;
    check("snoozing", int'(snoozing), 1);
    check("snooze_quiet", int'(alarm), 0);
    wait_ticks(SNOOZE_SEC);
    check("snooze_last", int'(snoozing), 1);
    @(negedge clock);
    check("rering", int'(alarm), 1);
    check("rering_src", int'(alarm_src), 5);
    stop_alarm = 1'b1; snooze = 1'b1; @(negedge clock);
    stop_alarm = 1'b0; snooze = 1'b0;
    check("stop_alarm", int'(alarm), 0);
    check("stop_snz", int'(snoozing), 0);
    check("stop_src", int'(alarm_src), 0);

    // Asynchronous reset mid-ring and mid-prescale.
    load_time(6, 29);
    wait_ticks(60);
    @(negedge clock);
    check("alarm_rise3", int'(alarm), 1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_idle_outs("async_reset");
    @(negedge clock);
    reset = 1'b0;
    alarm_en = 3'b010;
    load_time(23, 59);
    wait_ticks(60);
    check_time("rst_wrap", 0, 0, 0);
    @(negedge clock);
    check("slot_reset_match", int'(alarm), 1);
    check("slot_reset_src", int'(alarm_src), 2);
    stop_alarm = 1'b1; @(negedge clock); stop_alarm = 1'b0;

    // Random phase: loads cluster near the alarm slots so episodes occur.
    load_alarm(0, 6, 2);
    load_alarm(1, 6, 5);
    load_alarm(2, 6, 1);
    alarm_en = 3'b111;
    load_time(6, 0);
    for (int c = 0; c < 40000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) begin
        set_h1 = 2'($urandom); set_h0 = 4'($urandom);
        set_m1 = 3'($urandom); set_m0 = 4'($urandom);
      end else begin
        set_hm(($urandom_range(0, 9) == 0) ? 23 : 6, $urandom_range(0, 5));
      end
      alarm_sel  = AIDX_W'($urandom);
      ld_time    = ($urandom_range(0, 999) == 0);
      ld_alarm   = ($urandom_range(0, 149) == 0);
      stop_alarm = ($urandom_range(0, 2999) == 0);
      snooze     = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 499) == 0) alarm_en = N_ALARMS'($urandom);
    end
    ld_time = 0; ld_alarm = 0; stop_alarm = 0; snooze = 0;
    repeat (5) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
Parametrised 24-hour BCD real-time clock with N independently programmable hh:mm alarms, snooze, and ring timeout. It is the next generation of the single-alarm clock block. A system-clock prescaler generates a 1 s tick. Time and alarm registers are loaded from BCD inputs with range checking. A 3-state ring controller drives a single alarm output and reports which alarm(s) caused it.

Parameters:
CLK_HZ, 10, clock cycles per second (>=2)
N_ALARMS, 4, number of alarm slots (1..16)
AIDX_W, 2, width of alarm_sel (>= clog2(N_ALARMS), min 1)
SNOOZE_SEC, 300, snooze duration in seconds (>=1)
RING_SEC, 60, ring time with no user action before auto-stop (>=1)

Ports:
clock  in  1  system clock
reset  in  1  reset, asynchronous, active-high
ld_time  in  1  load clock time from set_* this cycle
ld_alarm  in  1  load alarm[alarm_sel] from set_* this cycle
alarm_sel  in  AIDX_W  target slot for ld_alarm
set_h1  in  2  BCD hour tens
set_h0  in  4  BCD hour units
set_m1  in  3  BCD minute tens
set_m0  in  4  BCD minute units
alarm_en  in  N_ALARMS  per-slot arm enable (level)
stop_alarm  in  1  stop ringing/snooze (level, sampled each cycle)
snooze  in  1  snooze request (level, sampled each cycle)
h1,h0,m1,m0,s1,s0  out  2,4,3,4,3,4  current time, BCD
tick_1s  out  1  one-cycle pulse per second
alarm  out  1  high while ringing
alarm_src  out  N_ALARMS  accumulated source slots of current alarm episode
snoozing  out  1  high in SNOOZE state
ld_err  out  1  one-cycle pulse on rejected load

Behaviour:
- Reset (async): time 00:00:00; prescaler 0; all alarm slots 00:00; state IDLE; alarm, alarm_src, snoozing, tick_1s, ld_err all 0.
- Prescaler: counts 0..CLK_HZ-1. tick_1s is registered and high for exactly one cycle when the count wraps, i.e. every CLK_HZ cycles.
- On tick, time advances by 1 s with BCD carries: s0 9->0 carries to s1; s1 5->0 carries to m0, and so on. 23:59:59 wraps to 00:00:00. No invalid BCD ever appears on the outputs.
- Load validity rule: valid iff h1<=2, h0<=9, (h1<2 or h0<=3), m1<=5, m0<=9.
- ld_time with valid set_*: next cycle time = set hh:mm:00 and prescaler = 0. This overrides a tick in the same cycle; no tick_1s is emitted that cycle.
- ld_time with invalid set_*: time unchanged; ld_err pulses 1 cycle.
- ld_alarm: if set_* is valid and alarm_sel < N_ALARMS, the slot is written. Otherwise the slot is unchanged and ld_err pulses.
- ld_time and ld_alarm in the same cycle: both are evaluated independently. ld_err pulses if either is rejected.
- Match event for slot i: a tick advances the time to ss=00, the new hh:mm equals slot i, and alarm_en[i]=1.
  - Evaluated in the same cycle the new time is registered; alarm rises on the next cycle.
  - Loading the time never produces a match.
  - Multiple slots may match at once.
- Ring FSM, states IDLE, RINGING, SNOOZE; priority stop_alarm > snooze > match.
  - IDLE: any match -> RINGING. alarm_src = matching slots; ring counter = RING_SEC.
  - RINGING:
    - stop_alarm -> IDLE; alarm_src cleared.
    - Else snooze -> SNOOZE; snooze counter = SNOOZE_SEC.
    - Else each tick decrements the ring counter; reaching 0 -> IDLE with alarm_src cleared.
    - A new match ORs into alarm_src and reloads the ring counter.
  - SNOOZE:
    - stop_alarm -> IDLE; alarm_src cleared.
    - Else a match or the snooze counter reaching 0 on a tick -> RINGING. A match ORs into alarm_src. The ring counter reloads.
    - snooze while in SNOOZE is ignored.
  - A match in the same cycle as stop_alarm is discarded.
- Outputs: alarm = (state==RINGING); snoozing = (state==SNOOZE). Both registered.
- Deasserting alarm_en[i] does not stop an episode already in progress.
- Counter widths are sized from the parameters; neither counter underflows below 0.

Test Plan:
- Reset, CLK_HZ=10, run 10 cycles -> tick_1s pulses once, on the 10th cycle; time 00:00:01.
- ld_time 23:59, run 60 ticks -> time 00:00:00 after the last tick. Verify h1/h0 wrap and that all intermediate BCD values are legal.
- ld_time 24:00 and, separately, 12:60 -> ld_err pulses once each; time unchanged. ld_alarm with alarm_sel=N_ALARMS (N_ALARMS=3) -> ld_err pulses.
- Slots 0 and 2 set to 06:30, alarm_en=101, time 06:29:59, one tick -> alarm=1 next cycle, alarm_src=101. With RING_SEC=60 and no action, alarm=0 after 60 ticks and alarm_src=000.
- Ringing, snooze pulse -> snoozing=1, alarm=0. With SNOOZE_SEC=300, alarm=1 again after 300 ticks. Then assert stop_alarm and snooze together -> IDLE, alarm_src=0.
- Assert reset mid-ring and mid-prescale -> all outputs 0 and time 00:00:00 immediately; alarm slots read back 00:00, so a time of 00:00 with alarm_en set matches at the next 00:00:00 rollover.
